// File: rtl/digest_serializer.sv
// Width converter: accepts one whole digest per input beat and emits it as
// narrower AXI-Stream beats, with tlast on the final byte-qualified beat.
module digest_serializer #(
  parameter int S_AXIS_DATA_WIDTH  = 512,
  parameter int M_AXIS_DATA_WIDTH  = 64,
  parameter int S_AXIS_TUSER_WIDTH = 128,
  parameter int M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int OB    = M_AXIS_DATA_WIDTH / 8;
  localparam int SB    = S_AXIS_DATA_WIDTH / 8;
  localparam int NB    = S_AXIS_DATA_WIDTH / M_AXIS_DATA_WIDTH;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state, state_d;
  logic [IDX_W-1:0]                beat_idx, beat_idx_d;
  logic [IDX_W-1:0]                last_idx, last_idx_d;
  logic [IDX_W-1:0]                nxt_idx, in_last;
  logic [S_AXIS_DATA_WIDTH-1:0]    hold_data, hold_data_d;
  logic [SB-1:0]                   hold_keep, hold_keep_d;
  logic [S_AXIS_TUSER_WIDTH-1:0]   hold_user, hold_user_d;
  logic [M_AXIS_DATA_WIDTH-1:0]    out_data, out_data_d;
  logic [OB-1:0]                   out_keep, out_keep_d;
  logic [M_AXIS_TUSER_WIDTH-1:0]   out_user, out_user_d;
  logic                            out_last, out_last_d;
  int unsigned                     keep_cnt;
  logic                            unused_tlast;

  assign unused_tlast = s_axis_tlast;

  // Index of the final beat; irrelevant when tkeep is all zero.
  always_comb begin
    keep_cnt = 0;
    for (int unsigned i = 0; i < SB; i++) begin
      keep_cnt = keep_cnt + 32'(s_axis_tkeep[i]);
    end
    in_last = IDX_W'((keep_cnt + OB - 1) / OB - 1);
  end

  always_comb begin
    state_d     = state;
    beat_idx_d  = beat_idx;
    last_idx_d  = last_idx;
    hold_data_d = hold_data;
    hold_keep_d = hold_keep;
    hold_user_d = hold_user;
    out_data_d  = out_data;
    out_keep_d  = out_keep;
    out_user_d  = out_user;
    out_last_d  = out_last;
    nxt_idx     = beat_idx + 1'b1;
    case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          hold_data_d = s_axis_tdata;
          hold_keep_d = s_axis_tkeep;
          hold_user_d = s_axis_tuser;
          last_idx_d  = in_last;
          beat_idx_d  = '0;
          // Beat 0 is loaded straight from the input so outputs stay registered.
          if (|s_axis_tkeep) begin
            state_d    = SEND;
            out_data_d = s_axis_tdata[M_AXIS_DATA_WIDTH-1:0];
            out_keep_d = s_axis_tkeep[OB-1:0];
            out_user_d = s_axis_tuser;
            out_last_d = (in_last == '0);
          end
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (out_last) begin
            state_d = IDLE;
          end else begin
            beat_idx_d = nxt_idx;
            out_data_d = hold_data[nxt_idx*M_AXIS_DATA_WIDTH +: M_AXIS_DATA_WIDTH];
            out_keep_d = hold_keep[nxt_idx*OB +: OB];
            out_last_d = (nxt_idx == last_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= IDLE;
      beat_idx  <= '0;
      last_idx  <= '0;
      hold_data <= '0;
      hold_keep <= '0;
      hold_user <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      beat_idx  <= beat_idx_d;
      last_idx  <= last_idx_d;
      hold_data <= hold_data_d;
      hold_keep <= hold_keep_d;
      hold_user <= hold_user_d;
      out_data  <= out_data_d;
      out_keep  <= out_keep_d;
      out_user  <= out_user_d;
      out_last  <= out_last_d;
    end
  end

  assign s_axis_tready = (state == IDLE);
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tuser  = out_user;
  assign m_axis_tlast  = out_last & (state == SEND);

endmodule

// File: doc/digest_serializer.md
# digest_serializer

Downstream width-converting stage for the SHA-2 datapath. Accepts one complete big-endian message digest per input beat (up to 512 bits, byte-qualified by `s_axis_tkeep`) from the digest stage. Emits it as a sequence of narrower AXI-Stream beats with per-beat `tkeep` and `tlast` on the final beat. Feeds the host/DMA-facing output interface.

## Interface

Parameters:
- `S_AXIS_DATA_WIDTH`, 512: input digest width; a multiple of `M_AXIS_DATA_WIDTH`.
- `M_AXIS_DATA_WIDTH`, 64: output beat width; a multiple of 8.
- `S_AXIS_TUSER_WIDTH`, 128: input sideband width.
- `M_AXIS_TUSER_WIDTH`, 128: output sideband width; equals `S_AXIS_TUSER_WIDTH`.

Ports:
- `axi_aclk`  in  1  single clock for the whole block.
- `axi_resetn`  in  1  reset; asynchronous, active-low.
- `s_axis_tdata`  in  `S_AXIS_DATA_WIDTH`  digest; byte 0 in bits [7:0].
- `s_axis_tkeep`  in  `S_AXIS_DATA_WIDTH/8`  valid digest bytes, contiguous from byte 0.
- `s_axis_tuser`  in  `S_AXIS_TUSER_WIDTH`  sideband, carried unchanged.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tlast`  in  1  ignored; every input beat is a complete digest.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  `M_AXIS_DATA_WIDTH`  output beat.
- `m_axis_tkeep`  out  `M_AXIS_DATA_WIDTH/8`  valid bytes of the beat.
- `m_axis_tuser`  out  `M_AXIS_TUSER_WIDTH`  sideband of the digest being sent.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  final beat of the digest.

## Operation

- Define `OB = M_AXIS_DATA_WIDTH/8` and `NB = S_AXIS_DATA_WIDTH/M_AXIS_DATA_WIDTH`.
- The FSM has two states: IDLE and SEND.
- **IDLE:**
  - `s_axis_tready` = 1.
  - On `s_axis_tvalid && s_axis_tready`, latch tdata, tkeep and tuser into a holding register.
  - Compute `last_idx = ceil(popcount(tkeep)/OB) - 1`.
  - Clear `beat_idx` to 0.
  - If `tkeep` is all zero, consume the digest, produce no output, and stay in IDLE.
  - Otherwise go to SEND.
- **SEND:**
  - `s_axis_tready` = 0.
  - `m_axis_tdata` = `hold_data[beat_idx*M_AXIS_DATA_WIDTH +: M_AXIS_DATA_WIDTH]`.
  - `m_axis_tkeep` = `hold_keep[beat_idx*OB +: OB]`.
  - `m_axis_tuser` = `hold_user` on every beat.
  - `m_axis_tlast` = (`beat_idx == last_idx`).
  - On `m_axis_tvalid && m_axis_tready`:
    - If not the last beat, increment `beat_idx`.
    - On the last beat, return to IDLE.
- `beat_idx` width is `clog2(NB)`, minimum 1. It never exceeds `last_idx` and never wraps.
- Output bytes are never reordered; the upstream stage has already applied big-endian ordering.
- Expected results for the default widths:
  - SHA224 (28 bytes): 4 beats, last tkeep 0x0F.
  - SHA256 (32 bytes): 4 beats, last tkeep 0xFF.
  - SHA384 (48 bytes): 6 beats.
  - SHA512 (64 bytes): 8 beats.

## Timing

- **Reset values:** `s_axis_tready` = 1; `m_axis_tvalid`, `m_axis_tlast` = 0; `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser` = 0. The FSM is in IDLE and `beat_idx` = 0.
- **Registered outputs:** all outputs are registered. There is no combinational path from `m_axis_tready` to `s_axis_tready`.
- **Latency:** input accepted at edge N gives the first output beat valid after edge N. Each following beat advances one cycle per accepted handshake.
- **Handoff:** when the last beat is accepted at edge M, `m_axis_tvalid` falls and `s_axis_tready` rises after edge M. The next digest can be accepted at edge M+1. For a K-beat digest the minimum cycles per digest is K+1.
- **AXI rules:**
  - While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, tdata, tkeep, tuser and tlast hold stable.
  - `m_axis_tvalid` never drops before its handshake.
- **Backpressure:** held `m_axis_tready` = 0 stalls indefinitely with no data loss.
- **Reset mid-packet:** assertion of `axi_resetn` = 0 forces all reset values immediately, asynchronously, and discards the held digest. After release, the first rising edge starts in IDLE.
- **Input while busy:** `s_axis_tvalid` high during SEND is not accepted. It must be presented again in IDLE, per AXI.

## Test plan

- **SHA512:** input tkeep all ones, tdata bytes 0x00..0x3F, tuser 0x3 in bits [33:32] → 8 beats with tkeep 0xFF. Beat 0 tdata = 0x0706050403020100, beat 7 = 0x3F3E3D3C3B3A3938, tlast only on beat 7, tuser constant.
- **SHA224:** tkeep = 28 ones → 4 beats. Beat 3 tkeep = 0x0F with tlast = 1. `s_axis_tready` is 0 from the cycle after acceptance until the cycle after beat 3 is accepted.
- **Backpressure:** SHA384 digest with `m_axis_tready` toggling 1,0,0,1 repeatedly → exactly 6 beats with correct data. Outputs stay stable during every stall.
- **Back-to-back:** SHA256 digest then SHA512 digest with `s_axis_tvalid` held high and `m_axis_tready` = 1 → 4 beats, one idle cycle, then 8 beats. Second acceptance occurs on the cycle after the first packet's tlast handshake.
- **Reset mid-packet:** assert reset after beat 2 of a SHA512 digest → `m_axis_tvalid` = 0 and `s_axis_tready` = 1 immediately. A new SHA256 digest then yields 4 beats starting from byte 0.
- **Zero keep:** input tkeep = 0 → accepted, no output beats, `s_axis_tready` stays 1.
